// File: rtl/pcie_led_status_if.sv
// Signal bundle between the PCIe status sources and the QSFP LED driver.
// The beat inputs are already tvalid&tready of each AXIS channel (one per accepted transfer).
interface pcie_led_status_if;
    logic        rq_beat;
    logic        rc_beat;
    logic        cq_beat;
    logic        cc_beat;
    logic        link_up;
    logic        status_error_cor;
    logic        status_error_uncor;
    logic        err_clear;
    logic        qsfp_led_act;
    logic        qsfp_led_stat_g;
    logic        qsfp_led_stat_y;
    logic [15:0] err_cor_count;
    logic [15:0] err_uncor_count;
    logic [1:0]  dbg_state;

    modport master (
        output rq_beat, rc_beat, cq_beat, cc_beat, link_up,
               status_error_cor, status_error_uncor, err_clear,
        input  qsfp_led_act, qsfp_led_stat_g, qsfp_led_stat_y,
               err_cor_count, err_uncor_count, dbg_state
    );

    modport slave (
        input  rq_beat, rc_beat, cq_beat, cc_beat, link_up,
               status_error_cor, status_error_uncor, err_clear,
        output qsfp_led_act, qsfp_led_stat_g, qsfp_led_stat_y,
               err_cor_count, err_uncor_count, dbg_state
    );
endinterface

// File: rtl/pcie_led_status.sv
// QSFP LED driver: activity hold, link/error status FSM with link-down blink,
// and saturating correctable/uncorrectable error counters.
module pcie_led_status #(
    parameter int unsigned ACT_HOLD_CYCLES   = 12500000,
    parameter int unsigned BLINK_HALF_CYCLES = 62500000,
    parameter int unsigned ERR_HOLD_CYCLES   = 250000000
) (
    input  logic             clk,
    input  logic             rst_n,
    pcie_led_status_if.slave io_bus
);
    localparam logic [1:0] ST_LINK_DOWN = 2'd0;
    localparam logic [1:0] ST_LINK_UP   = 2'd1;
    localparam logic [1:0] ST_ERR_COR   = 2'd2;
    localparam logic [1:0] ST_ERR_UNCOR = 2'd3;

    localparam logic [23:0] ACT_LOAD   = 24'(ACT_HOLD_CYCLES);
    localparam logic [26:0] BLINK_LAST = 27'(BLINK_HALF_CYCLES - 1);
    localparam logic [27:0] ERR_LOAD   = 28'(ERR_HOLD_CYCLES);

    logic [1:0]  r_state;
    logic [23:0] r_act_cnt;
    logic [26:0] r_blink_cnt;
    logic        r_blink_y;
    logic [27:0] r_err_timer;
    logic        r_led_act;
    logic        r_led_g;
    logic        r_led_y;
    logic [15:0] r_cor_cnt;
    logic [15:0] r_uncor_cnt;

    logic        w_any_beat;
    logic [23:0] w_act_next;
    logic [1:0]  w_state_next;
    logic [26:0] w_blink_cnt_next;
    logic        w_blink_y_next;
    logic [27:0] w_err_timer_next;
    logic        w_led_g_next;
    logic        w_led_y_next;
    logic [15:0] w_cor_next;
    logic [15:0] w_uncor_next;

    function automatic logic [15:0] sat_count(input logic [15:0] cnt,
                                              input logic        pulse,
                                              input logic        clr);
        logic [15:0] res;
        if (clr)
            res = {15'd0, pulse};
        else if (pulse && (cnt != 16'hFFFF))
            res = cnt + 16'd1;
        else
            res = cnt;
        return res;
    endfunction

    always_comb begin
        w_any_beat = io_bus.rq_beat | io_bus.rc_beat | io_bus.cq_beat | io_bus.cc_beat;
        if (w_any_beat)
            w_act_next = ACT_LOAD;
        else if (r_act_cnt != 24'd0)
            w_act_next = r_act_cnt - 24'd1;
        else
            w_act_next = 24'd0;
    end

    // Priority chain: link loss, uncorrectable, clear, correctable, timer expiry, link-up.
    always_comb begin
        w_state_next     = r_state;
        w_blink_cnt_next = 27'd0;
        w_blink_y_next   = 1'b0;
        w_err_timer_next = 28'd0;
        if (!io_bus.link_up) begin
            w_state_next = ST_LINK_DOWN;
            if (r_state == ST_LINK_DOWN) begin
                if (r_blink_cnt >= BLINK_LAST) begin
                    w_blink_cnt_next = 27'd0;
                    w_blink_y_next   = ~r_blink_y;
                end else begin
                    w_blink_cnt_next = r_blink_cnt + 27'd1;
                    w_blink_y_next   = r_blink_y;
                end
            end
        end else if (io_bus.status_error_uncor) begin
            w_state_next = ST_ERR_UNCOR;
        end else if (io_bus.err_clear && (r_state == ST_ERR_UNCOR)) begin
            w_state_next = ST_LINK_UP;
        end else if (io_bus.status_error_cor &&
                     ((r_state == ST_LINK_UP) || (r_state == ST_ERR_COR))) begin
            w_state_next     = ST_ERR_COR;
            w_err_timer_next = ERR_LOAD;
        end else if (r_state == ST_ERR_COR) begin
            if (r_err_timer <= 28'd1)
                w_state_next = ST_LINK_UP;
            else
                w_err_timer_next = r_err_timer - 28'd1;
        end else if (r_state == ST_LINK_DOWN) begin
            w_state_next = ST_LINK_UP;
        end
    end

    always_comb begin
        w_led_g_next = (w_state_next == ST_LINK_UP) || (w_state_next == ST_ERR_COR);
        case (w_state_next)
            ST_LINK_DOWN: w_led_y_next = w_blink_y_next;
            ST_LINK_UP:   w_led_y_next = 1'b0;
            default:      w_led_y_next = 1'b1;
        endcase
        w_cor_next   = sat_count(r_cor_cnt, io_bus.status_error_cor, io_bus.err_clear);
        w_uncor_next = sat_count(r_uncor_cnt, io_bus.status_error_uncor, io_bus.err_clear);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_LINK_DOWN;
            r_act_cnt   <= 24'd0;
            r_blink_cnt <= 27'd0;
            r_blink_y   <= 1'b0;
            r_err_timer <= 28'd0;
            r_led_act   <= 1'b0;
            r_led_g     <= 1'b0;
            r_led_y     <= 1'b0;
            r_cor_cnt   <= 16'd0;
            r_uncor_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            r_act_cnt   <= w_act_next;
            r_blink_cnt <= w_blink_cnt_next;
            r_blink_y   <= w_blink_y_next;
            r_err_timer <= w_err_timer_next;
            r_led_act   <= (w_act_next != 24'd0);
            r_led_g     <= w_led_g_next;
            r_led_y     <= w_led_y_next;
            r_cor_cnt   <= w_cor_next;
            r_uncor_cnt <= w_uncor_next;
        end
    end

    assign io_bus.qsfp_led_act    = r_led_act;
    assign io_bus.qsfp_led_stat_g = r_led_g;
    assign io_bus.qsfp_led_stat_y = r_led_y;
    assign io_bus.err_cor_count   = r_cor_cnt;
    assign io_bus.err_uncor_count = r_uncor_cnt;
    assign io_bus.dbg_state       = r_state;
endmodule
